// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory-access pipeline stage.
// Access-size decoding and byte-enable generation live here so the stage and its load aligner agree.
package mem_stage_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Everything the request port needs, captured once when the op is accepted.
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [3:0]      be;
        logic            we;
        logic [2:0]      funct3;
        logic [4:0]      rd;
        logic            reg_write;
    } req_lat_t;

    function automatic logic is_byte(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_BU);
    endfunction

    function automatic logic is_half(input logic [2:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

    // Unknown funct3 codes fall through to a full-word access.
    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
        if (is_byte(f3))
            return 4'b0001 << a;
        else if (is_half(f3))
            return a[1] ? 4'b1100 : 4'b0011;
        else
            return 4'b1111;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/response port of the memory stage.
// master = pipeline stage issuing requests, slave = memory / network interface.
interface mem_access_stage_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_load_align.sv
// Load aligner: picks the addressed byte/half from the returned word and sign/zero extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[7:0];
        case (addr_lo)
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            2'd3:    lane_b = rdata[31:24];
            default: lane_b = rdata[7:0];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    result = {{24{lane_b[7]}}, lane_b};
            F3_BU:   result = {24'd0, lane_b};
            F3_H:    result = {{16{lane_h[15]}}, lane_h};
            F3_HU:   result = {16'd0, lane_h};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: issues loads/stores on a valid/ready port and registers results for write-back. Macro MEM_MISALIGN_TRAP_EN enables misalignment trapping.
// Latency: ALU op 1 cycle; store >= 2 cycles; load >= 3 cycles (ex_valid -> wb_valid).
// Backpressure: stall_M holds upstream while a request is outstanding; req_* stay stable until req_ready.
module mem_access_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        ex_valid,
    input  logic [31:0] ALU_result_E,
    input  logic [31:0] Write_Data_E,
    input  logic [4:0]  rd_E,
    input  logic        reg_write_E,
    input  logic        mem_read_E,
    input  logic        mem_write_E,
    input  logic [2:0]  funct3_E,

    output logic        stall_M,

    mem_access_stage_if.master mem,

    output logic        wb_valid,
    output logic        reg_write_M,
    output logic [4:0]  rd_M,
    output logic [31:0] result_M,
    output logic        misalign_M
);

    state_t      state, state_nxt;
    req_lat_t    lat;
    logic        mem_op;
    logic        accept;
    logic        misaligned;
    logic        start_mem;
    logic        req_hs;
    logic        rsp_take;
    logic [31:0] wdata_fmt;
    logic [31:0] load_val;

    assign mem_op    = mem_read_E | mem_write_E;
    assign accept    = (state == IDLE) & ex_valid;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = is_half(funct3_E) ? ALU_result_E[0]
                                          : (!is_byte(funct3_E) && (ALU_result_E[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign start_mem = accept & mem_op & ~misaligned;
    assign req_hs    = (state == REQ) & mem.req_ready;
    assign rsp_take  = (state == WAIT_RSP) & mem.rsp_valid;

    // Lane replication lets memory pick bytes purely from req_be.
    always_comb begin
        if (is_byte(funct3_E))
            wdata_fmt = {4{Write_Data_E[7:0]}};
        else if (is_half(funct3_E))
            wdata_fmt = {2{Write_Data_E[15:0]}};
        else
            wdata_fmt = Write_Data_E;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        mem.req_valid = 1'b0;
        stall_M       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start_mem)
                    state_nxt = REQ;
            end
            REQ: begin
                mem.req_valid = 1'b1;
                if (mem.req_ready)
                    state_nxt = lat.we ? IDLE : WAIT_RSP;
            end
            WAIT_RSP: begin
                if (mem.rsp_valid)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request outputs come only from registers, never from req_ready/rsp_valid.
    assign mem.req_we    = lat.we;
    assign mem.req_addr  = {lat.addr[31:2], 2'b00};
    assign mem.req_wdata = lat.wdata;
    assign mem.req_be    = lat.be;

    mem_load_align u_load_align (
        .rdata   (mem.rsp_rdata),
        .addr_lo (lat.addr[1:0]),
        .funct3  (lat.funct3),
        .result  (load_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat         <= '0;
            wb_valid    <= 1'b0;
            reg_write_M <= 1'b0;
            rd_M        <= 5'd0;
            result_M    <= 32'd0;
        end else begin
            wb_valid <= 1'b0;
            if (accept) begin
                if (!mem_op) begin
                    wb_valid    <= 1'b1;
                    reg_write_M <= reg_write_E;
                    rd_M        <= rd_E;
                    result_M    <= ALU_result_E;
                end else if (misaligned) begin
                    wb_valid    <= 1'b1;
                    reg_write_M <= 1'b0;
                    rd_M        <= rd_E;
                end else begin
                    lat.addr      <= ALU_result_E;
                    lat.wdata     <= wdata_fmt;
                    lat.be        <= byte_en(funct3_E, ALU_result_E[1:0]);
                    lat.we        <= mem_write_E;
                    lat.funct3    <= funct3_E;
                    lat.rd        <= rd_E;
                    lat.reg_write <= reg_write_E;
                end
            end
            if (req_hs && lat.we) begin
                wb_valid    <= 1'b1;
                reg_write_M <= 1'b0;
                rd_M        <= lat.rd;
            end
            if (rsp_take) begin
                wb_valid    <= 1'b1;
                reg_write_M <= lat.reg_write;
                rd_M        <= lat.rd;
                result_M    <= load_val;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misalign_M <= 1'b0;
        else
            misalign_M <= accept & mem_op & misaligned;
    end
`else
    assign misalign_M = 1'b0;
`endif

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the core pipeline; consumes execute-stage results (ALU result as address or passthrough value, store data, destination register, control) and performs loads/stores over a valid/ready request port toward data memory / the node's network interface. Stalls the pipeline while a memory transaction is outstanding. Registers results for write-back.

## Interface
- XLEN, 32, data/address width (only 32 supported)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  execute stage presents an instruction this cycle
- ALU_result_E  in  32  ALU result; memory address for loads/stores
- Write_Data_E  in  32  store data (unaligned, low bits significant)
- rd_E  in  5  destination register
- reg_write_E, mem_read_E, mem_write_E  in  1 each  control; mem_read_E and mem_write_E never both 1
- funct3_E  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes treated as W
- stall_M  out  1  pipeline must hold upstream stages
- req_valid, req_we  out  1 each  request valid; 1 = store
- req_addr  out  32  word address (low two bits 0)
- req_wdata  out  32  lane-replicated store data
- req_be  out  4  byte enables
- req_ready  in  1  memory accepts request
- rsp_valid  in  1  load data valid
- rsp_rdata  in  32  load word
- wb_valid, reg_write_M  out  1 each  write-back strobe / register write enable
- rd_M  out  5  destination register
- result_M  out  32  value to write back
- misalign_M  out  1  misaligned access flag (see Configuration)

## Operation
- FSM states: IDLE, REQ, WAIT_RSP. stall_M = (state != IDLE).
- IDLE, ex_valid, no mem op: register rd/reg_write/ALU result to outputs; wb_valid=1 next cycle.
- IDLE, ex_valid, mem op: latch address, data, funct3, rd, reg_write; go REQ.
- REQ: req_valid=1; req_* driven from latched registers only, stable until handshake (req_valid & req_ready).
  - Store handshake: wb_valid=1 next cycle with reg_write_M=0; go IDLE.
  - Load handshake: go WAIT_RSP.
- WAIT_RSP: on rsp_valid, select lane by addr[1:0] (H uses addr[1]), sign- (B,H) or zero-extend (BU,HU), W passes through; register to result_M, wb_valid=1 next cycle; go IDLE.
- Store formatting: B: be=0001<<addr[1:0], wdata={4{byte}}; H: be=0011<<(2*addr[1]), wdata={2{half}}; W: be=1111.
- rsp_valid outside WAIT_RSP ignored. ex_valid while stall_M=1 ignored (upstream holds).
- Reset: all outputs 0, state IDLE; reset mid-transaction drops req_valid immediately; late response ignored.

## Timing
- Non-memory op: 1-cycle latency ex_valid -> wb_valid.
- Store: ex_valid at T, req_valid from T+1, wb_valid the cycle after handshake; min 2 cycles.
- Load: wb_valid cycle after rsp_valid; rsp_valid earliest cycle after request handshake; min 3 cycles.
- wb_valid is a single-cycle pulse per instruction; stall_M deasserts the same cycle wb_valid asserts for memory ops.
- No combinational path from req_ready/rsp_valid to req_* outputs.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: H at odd address or W with addr[1:0]!=0 issues no request; misalign_M=1 and wb_valid=1 (reg_write_M=0) one cycle after ex_valid; FSM stays IDLE.
- Undefined: misalign_M tied 0; low address bits beyond access size ignored (access aligned down, lane from remaining bits).

## Structure
- Package mem_stage_pkg: state enum, funct3 size constants, byte-enable helper.
- Sub-module mem_load_align: combinational lane select and sign/zero extension (rdata, addr[1:0], funct3 -> 32-bit result).

## Test plan
- ALU op rd=5, result 0x00001234 -> next cycle wb_valid=1, rd_M=5, result_M=0x00001234, req_valid never 1.
- SB addr 0x1003 data 0x000000AB, req_ready low 3 cycles -> req_addr 0x1000, be 1000, wdata 0xABABABAB stable, stall_M high until handshake, then wb_valid with reg_write_M=0.
- LH addr 0x2002, rsp_rdata 0x80017FFF -> result_M 0xFFFF8001; LHU same -> 0x00008001; LB addr 0x2001 -> 0x0000007F.
- LW addr 0x4000, rsp_valid 5 cycles after handshake, spurious rsp_valid in IDLE beforehand -> stall_M high throughout, single wb_valid one cycle after real rsp_valid, spurious ignored.
- LW addr 0x3001 -> with MEM_MISALIGN_TRAP_EN misalign_M=1, no req_valid; without, req_addr 0x3000, be 1111.
- rst asserted in WAIT_RSP -> req_valid, stall_M, wb_valid 0 immediately; following rsp_valid produces no wb_valid.
